// File: rtl/sec_enc32.sv
// sec_enc32: two-stage valid/ready SEC check-bit generator for 32-bit words; SEC_ENC_ERRINJ_EN adds single-bit error injection
module sec_enc32 #(
    parameter int CNT_W = 16
) (
    input  logic             Gclk,
    input  logic             Grst_n,
    input  logic             Gin_valid,
    output logic             Gin_ready,
    input  logic [31:0]      Gid,
    output logic             Gout_valid,
    input  logic             Gout_ready,
    output logic [31:0]      God,
    output logic [7:0]       Goc,
    output logic [CNT_W-1:0] Gcnt,
    input  logic             Ginj_req,
    input  logic [5:0]       Ginj_pos
);
    logic             v1_q, v1_d, v2_q, v2_d;
    logic [31:0]      d1_q, d1_d, god_q, god_d;
    logic [7:0]       f1_q, f1_d, e1_q, e1_d, goc_q, goc_d;
    logic [7:0]       f, e, g;
    logic [39:0]      flip;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             adv2, acc;
`ifdef SEC_ENC_ERRINJ_EN
    logic             inj_q, inj_d;
    logic [5:0]       pos_q, pos_d;
`else
    logic             unused_inj;
    assign unused_inj = ^{Ginj_req, Ginj_pos};
`endif

    assign adv2       = v1_q & (~v2_q | Gout_ready);
    assign Gin_ready  = Grst_n & (~v1_q | adv2);
    assign acc        = Gin_valid & Gin_ready;
    assign Gout_valid = v2_q;
    assign God        = god_q;
    assign Goc        = goc_q;
    assign Gcnt       = cnt_q;

    always_comb begin
        for (int i = 0; i < 8; i++) f[i] = ^Gid[4*i +: 4];
        for (int i = 0; i < 4; i++) begin
            e[i]   = Gid[i] ^ Gid[i+4] ^ Gid[i+8] ^ Gid[i+12];
            e[i+4] = Gid[i+16] ^ Gid[i+20] ^ Gid[i+24] ^ Gid[i+28];
        end
        g = {f1_q[5] ^ f1_q[7], f1_q[4] ^ f1_q[6], f1_q[6] ^ f1_q[7], f1_q[4] ^ f1_q[5],
             f1_q[1] ^ f1_q[3], f1_q[0] ^ f1_q[2], f1_q[2] ^ f1_q[3], f1_q[0] ^ f1_q[1]};
`ifdef SEC_ENC_ERRINJ_EN
        flip  = (inj_q && pos_q < 6'd40) ? (40'd1 << pos_q) : '0;
        inj_d = Ginj_req | (inj_q & ~adv2);
        pos_d = Ginj_req ? Ginj_pos : pos_q;
`else
        flip  = '0;
`endif
        v1_d = acc | (v1_q & ~adv2);
        d1_d = acc ? Gid : d1_q;
        f1_d = acc ? f : f1_q;
        e1_d = acc ? e : e1_q;
        v2_d = adv2 | (v2_q & ~Gout_ready);
        {goc_d, god_d} = adv2 ? ({e1_q ^ {g[3:0], g[7:4]}, d1_q} ^ flip) : {goc_q, god_q};
        cnt_d = cnt_q + CNT_W'(v2_q & Gout_ready);
    end

    always_ff @(posedge Gclk) begin
        if (!Grst_n) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            d1_q  <= '0;
            f1_q  <= '0;
            e1_q  <= '0;
            god_q <= '0;
            goc_q <= '0;
            cnt_q <= '0;
        end else begin
            v1_q  <= v1_d;
            v2_q  <= v2_d;
            d1_q  <= d1_d;
            f1_q  <= f1_d;
            e1_q  <= e1_d;
            god_q <= god_d;
            goc_q <= goc_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef SEC_ENC_ERRINJ_EN
    always_ff @(posedge Gclk) begin
        if (!Grst_n) begin
            inj_q <= 1'b0;
            pos_q <= '0;
        end else begin
            inj_q <= inj_d;
            pos_q <= pos_d;
        end
    end
`endif
endmodule
